ibex_pmp_csr: RTL and testbench

PMP CSR register file: the writer side of the PMP checker's configuration interface. It decodes machine-mode CSR accesses to pmpcfgN, pmpaddrN and mseccfg, applies the lock, WARL and sticky-bit rules, and holds the architectural state. It drives the packed cfg, addr and mseccfg buses consumed by the combinational PMP checker. It sits in the CSR unit, between the CSR access path and the checker.

---
 rtl/ibex_pmp_csr.sv | 163 ++++++++++++++++
 tb/tb_ibex_pmp_csr.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_pmp_csr.sv
// PMP CSR register file: decodes machine-mode accesses to pmpcfgN, pmpaddrN
// and mseccfg, applies lock / WARL / sticky rules and drives the packed
// configuration buses read by the combinational PMP checker.
module ibex_pmp_csr #(
    parameter int PMPGranularity = 0,
    parameter int PMPNumRegions  = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          csr_req_i,
    input  logic                          csr_we_i,
    input  logic [11:0]                   csr_addr_i,
    input  logic [31:0]                   csr_wdata_i,
    output logic [31:0]                   csr_rdata_o,
    output logic                          csr_illegal_o,
    output logic [PMPNumRegions*6-1:0]    csr_pmp_cfg_o,
    output logic [PMPNumRegions*34-1:0]   csr_pmp_addr_o,
    output logic [2:0]                    csr_pmp_mseccfg_o,
    output logic                          pmp_update_o
);

    localparam int N = PMPNumRegions;

    localparam logic [1:0] A_OFF   = 2'b00;
    localparam logic [1:0] A_TOR   = 2'b01;
    localparam logic [1:0] A_NA4   = 2'b10;
    localparam logic [1:0] A_NAPOT = 2'b11;

    // Mask with the n lowest bits set (n <= 0 gives an empty mask).
    function automatic logic [31:0] low_ones(input int n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [31:0] NAPOT_ONES = low_ones(PMPGranularity - 1);
    localparam logic [31:0] OFF_ZEROS  = low_ones(PMPGranularity);

    // WARL legalisation of one written cfg byte into the stored {L,A,X,W,R}.
    function automatic logic [5:0] legalise_cfg(input logic [7:0] wbyte, input logic mml);
        logic [5:0] c;
        c = {wbyte[7], wbyte[4:3], wbyte[2:0]};
        // W without R is reserved unless machine-mode lockdown gives it meaning
        if (!mml && c[1] && !c[0]) c[1:0] = 2'b00;
        // NA4 cannot describe a region coarser than four bytes
        if (PMPGranularity > 0 && c[4:3] == A_NA4) c[4:3] = A_OFF;
        return c;
    endfunction

    // Read view of pmpaddr: low bits depend on granule and address mode.
    function automatic logic [31:0] read_addr(input logic [31:0] a, input logic [1:0] mode);
        logic [31:0] v;
        v = a;
        if (mode == A_NAPOT) v = a | NAPOT_ONES;
        else if (mode == A_OFF || mode == A_TOR) v = a & ~OFF_ZEROS;
        return v;
    endfunction

    logic [N-1:0][5:0]  cfg_q, cfg_d;
    logic [N-1:0][31:0] addr_q, addr_d;
    logic [2:0]         msec_q, msec_d;
    logic               update_p1;

    logic is_cfg, is_addr, is_msec, is_msech;
    logic mml, rlb;
    logic any_locked;
    logic [N:0] tor_locked;
    logic state_changed;

    assign is_cfg   = (csr_addr_i[11:2] == 10'h0E8);
    assign is_addr  = (csr_addr_i[11:4] == 8'h3B);
    assign is_msec  = (csr_addr_i == 12'h747);
    assign is_msech = (csr_addr_i == 12'h757);

    assign csr_illegal_o = csr_req_i & ~(is_cfg | is_addr | is_msec | is_msech);

    assign mml = msec_q[0];
    assign rlb = msec_q[2];

    // Lock summary: any locked region, and regions that lock the pmpaddr below them via TOR.
    always_comb begin
        any_locked    = 1'b0;
        tor_locked[N] = 1'b0;
        for (int r = 0; r < N; r++) begin
            any_locked    = any_locked | cfg_q[r][5];
            tor_locked[r] = cfg_q[r][5] && (cfg_q[r][4:3] == A_TOR);
        end
    end

    // Next-state computation for a write, all checks against pre-edge state.
    always_comb begin
        cfg_d  = cfg_q;
        addr_d = addr_q;
        msec_d = msec_q;
        if (csr_req_i && csr_we_i) begin
            for (int r = 0; r < N; r++) begin
                if (is_cfg && (r / 4) == int'(csr_addr_i[1:0]) && !(cfg_q[r][5] && !rlb)) begin
                    cfg_d[r] = legalise_cfg(csr_wdata_i[(r % 4) * 8 +: 8], mml);
                end
                if (is_addr && r == int'(csr_addr_i[3:0]) &&
                    (rlb || !(cfg_q[r][5] || tor_locked[r+1]))) begin
                    addr_d[r] = csr_wdata_i;
                end
            end
            if (is_msec) begin
                msec_d[0] = msec_q[0] | csr_wdata_i[0];
                msec_d[1] = msec_q[1] | csr_wdata_i[1];
                if (rlb || !any_locked) msec_d[2] = csr_wdata_i[2];
            end
        end
    end

    assign state_changed = (cfg_d != cfg_q) || (addr_d != addr_q) || (msec_d != msec_q);

    // Architectural state and the change-notification pulse.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_q     <= '0;
            addr_q    <= '0;
            msec_q    <= '0;
            update_p1 <= 1'b0;
        end else begin
            cfg_q     <= cfg_d;
            addr_q    <= addr_d;
            msec_q    <= msec_d;
            update_p1 <= state_changed;
        end
    end

    assign pmp_update_o = update_p1;

    // Combinational read mux; unimplemented regions and idle cycles read zero.
    always_comb begin
        csr_rdata_o = '0;
        if (csr_req_i) begin
            for (int r = 0; r < N; r++) begin
                if (is_cfg && (r / 4) == int'(csr_addr_i[1:0])) begin
                    csr_rdata_o[(r % 4) * 8 +: 8] = {cfg_q[r][5], 2'b00, cfg_q[r][4:0]};
                end
                if (is_addr && r == int'(csr_addr_i[3:0])) begin
                    csr_rdata_o = read_addr(addr_q[r], cfg_q[r][4:3]);
                end
            end
            if (is_msec) csr_rdata_o[2:0] = msec_q;
        end
    end

    // Pack region state onto the checker buses, region 0 in the top slot.
    always_comb begin
        csr_pmp_cfg_o  = '0;
        csr_pmp_addr_o = '0;
        for (int r = 0; r < N; r++) begin
            csr_pmp_cfg_o[(N-1-r)*6 +: 6]   = cfg_q[r];
            csr_pmp_addr_o[(N-1-r)*34 +: 34] = {addr_q[r], 2'b00};
        end
    end

    assign csr_pmp_mseccfg_o = msec_q;

endmodule

// File: tb/tb_ibex_pmp_csr.sv
// Self-checking bench for ibex_pmp_csr: directed scenarios followed by
// randomized CSR traffic compared against a CSR-level reference model.
module tb_ibex_pmp_csr;

    localparam int N = 6;
    localparam int G = 2;

    logic               clk;
    logic               rst;
    logic               csr_req;
    logic               csr_we;
    logic [11:0]        csr_addr;
    logic [31:0]        csr_wdata;
    logic [31:0]        csr_rdata;
    logic               csr_illegal;
    logic [N*6-1:0]     cfg_bus;
    logic [N*34-1:0]    addr_bus;
    logic [2:0]         msec_bus;
    logic               pmp_update;

    ibex_pmp_csr #(
        .PMPGranularity (G),
        .PMPNumRegions  (N)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .csr_req_i         (csr_req),
        .csr_we_i          (csr_we),
        .csr_addr_i        (csr_addr),
        .csr_wdata_i       (csr_wdata),
        .csr_rdata_o       (csr_rdata),
        .csr_illegal_o     (csr_illegal),
        .csr_pmp_cfg_o     (cfg_bus),
        .csr_pmp_addr_o    (addr_bus),
        .csr_pmp_mseccfg_o (msec_bus),
        .pmp_update_o      (pmp_update)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: CSR-visible byte per region (bits 6:5 always 0).
    logic [7:0]  m_cfg  [16];
    logic [31:0] m_addr [16];
    bit          m_mml, m_mmwp, m_rlb;

    logic [31:0] obs_rd;
    logic        obs_ill;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) begin
            m_cfg[i]  = 8'h00;
            m_addr[i] = 32'h0;
        end
        m_mml  = 1'b0;
        m_mmwp = 1'b0;
        m_rlb  = 1'b0;
    endfunction

    function automatic bit model_illegal(input logic [11:0] a);
        return !((a >= 12'h3A0 && a <= 12'h3A3) || (a >= 12'h3B0 && a <= 12'h3BF) ||
                 a == 12'h747 || a == 12'h757);
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] a);
        int r;
        logic [31:0] v;
        if (a >= 12'h3A0 && a <= 12'h3A3) begin
            r = int'(a - 12'h3A0) * 4;
            return {m_cfg[r+3], m_cfg[r+2], m_cfg[r+1], m_cfg[r]};
        end
        if (a >= 12'h3B0 && a <= 12'h3BF) begin
            r = int'(a - 12'h3B0);
            v = m_addr[r];
            if (m_cfg[r][4:3] == 2'b11 && G >= 2) v = v | ((32'd1 << (G - 1)) - 32'd1);
            else if (m_cfg[r][4:3] <= 2'b01 && G >= 1) v = v & ~((32'd1 << G) - 32'd1);
            return v;
        end
        if (a == 12'h747) return {29'd0, m_rlb, m_mmwp, m_mml};
        return 32'h0;
    endfunction

    // Apply a committed write to the model; returns whether anything changed.
    function automatic bit model_write(input logic [11:0] a, input logic [31:0] d);
        bit ch;
        bit lk;
        bit anyl;
        bit nmml, nmmwp, nrlb;
        logic [7:0] nb;
        int r;
        ch = 1'b0;
        if (a >= 12'h3A0 && a <= 12'h3A3) begin
            for (int k = 0; k < 4; k++) begin
                r = int'(a - 12'h3A0) * 4 + k;
                if (r < N && !(m_cfg[r][7] && !m_rlb)) begin
                    nb = d[8*k +: 8] & 8'h9F;
                    if (!m_mml && nb[1:0] == 2'b10) nb[1:0] = 2'b00;
                    if (G > 0 && nb[4:3] == 2'b10) nb[4:3] = 2'b00;
                    if (nb != m_cfg[r]) ch = 1'b1;
                    m_cfg[r] = nb;
                end
            end
        end else if (a >= 12'h3B0 && a <= 12'h3BF) begin
            r = int'(a - 12'h3B0);
            if (r < N) begin
                lk = m_cfg[r][7];
                if (r + 1 < N && m_cfg[r+1][7] && m_cfg[r+1][4:3] == 2'b01) lk = 1'b1;
                if (m_rlb || !lk) begin
                    if (m_addr[r] != d) ch = 1'b1;
                    m_addr[r] = d;
                end
            end
        end else if (a == 12'h747) begin
            anyl = 1'b0;
            for (int i = 0; i < N; i++) anyl = anyl | m_cfg[i][7];
            nmml  = m_mml | d[0];
            nmmwp = m_mmwp | d[1];
            nrlb  = (m_rlb || !anyl) ? d[2] : m_rlb;
            if (nmml != m_mml || nmmwp != m_mmwp || nrlb != m_rlb) ch = 1'b1;
            m_mml  = nmml;
            m_mmwp = nmmwp;
            m_rlb  = nrlb;
        end
        return ch;
    endfunction

    task automatic check_buses();
        for (int r = 0; r < N; r++) begin
            chk($sformatf("cfg%0d", r), cfg_bus[(N-1-r)*6 +: 6], {m_cfg[r][7], m_cfg[r][4:0]});
            chk($sformatf("addr%0d", r), addr_bus[(N-1-r)*34 +: 34], {m_addr[r], 2'b00});
        end
        chk("mseccfg", msec_bus, {m_rlb, m_mmwp, m_mml});
    endtask

    // One access cycle: check combinational outputs before the edge, state after it.
    task automatic access(input bit req, input bit we, input logic [11:0] a, input logic [31:0] d);
        bit exp_upd;
        @(negedge clk);
        csr_req   = req;
        csr_we    = we;
        csr_addr  = a;
        csr_wdata = d;
        #1;
        obs_rd  = csr_rdata;
        obs_ill = csr_illegal;
        chk("rdata", csr_rdata, req ? model_read(a) : 32'h0);
        chk("illegal", csr_illegal, req && model_illegal(a));
        exp_upd = 1'b0;
        if (req && we) exp_upd = model_write(a, d);
        @(posedge clk);
        #1;
        chk("update", pmp_update, exp_upd);
        check_buses();
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        access(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [11:0] a);
        access(1'b1, 1'b0, a, 32'h0);
    endtask

    // Asynchronous reset between clock edges, optionally in the middle of a write.
    task automatic do_reset(input bit mid_write);
        @(negedge clk);
        if (mid_write) begin
            csr_req   = 1'b1;
            csr_we    = 1'b1;
            csr_addr  = 12'h3A0 + 12'($urandom_range(0, 1));
            csr_wdata = $urandom & 32'h7F7F7F7F;
        end
        #2 rst = 1'b1;
        #1;
        chk("rst_cfg", {28'd0, cfg_bus}, 64'd0);
        chk("rst_addr_or", {63'd0, |addr_bus}, 64'd0);
        chk("rst_msec", msec_bus, 64'd0);
        chk("rst_update", pmp_update, 64'd0);
        model_clear();
        @(negedge clk);
        csr_req = 1'b0;
        csr_we  = 1'b0;
        rst     = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [11:0] a;
        logic [31:0] d;
        bit          req, we;

        rst       = 1'b1;
        csr_req   = 1'b0;
        csr_we    = 1'b0;
        csr_addr  = 12'h0;
        csr_wdata = 32'h0;
        model_clear();

        do_reset(1'b0);
        access(1'b0, 1'b0, 12'h3A0, 32'h0);

        // Basic cfg write and readback
        wr(12'h3A0, 32'h0000_0F1B);
        chk("t1_r0cfg", cfg_bus[(N-1)*6 +: 6], 6'b011011);
        chk("t1_r1cfg", cfg_bus[(N-2)*6 +: 6], 6'b001111);
        chk("t1_pulse", pmp_update, 1);
        rd(12'h3A0);
        chk("t1_read", obs_rd, 32'h0000_0F1B);
        chk("t1_nopulse", pmp_update, 0);

        // Region1 locked as TOR protects pmpaddr0 and pmpaddr1
        wr(12'h3A0, 32'h0000_8F1B);
        wr(12'h3B0, 32'h0000_1234);
        chk("t2_a0_pulse", pmp_update, 0);
        wr(12'h3B1, 32'h0000_5678);
        chk("t2_a1_pulse", pmp_update, 0);
        chk("t2_addr0", addr_bus[(N-1)*34 +: 34], 34'h0);
        chk("t2_addr1", addr_bus[(N-2)*34 +: 34], 34'h0);

        // W-only encoding before and after MML
        wr(12'h3A0, 32'h0002_8F1B);
        chk("t3_r2_nomml", cfg_bus[(N-3)*6 +: 6], 6'b000000);
        wr(12'h747, 32'h1);
        wr(12'h3A0, 32'h0002_8F1B);
        chk("t3_r2_mml", cfg_bus[(N-3)*6 +: 6], 6'b000010);
        wr(12'h747, 32'h0);
        chk("t3_sticky", msec_bus, 3'b001);

        // Granularity masking and NA4 legalisation
        do_reset(1'b0);
        wr(12'h3B0, 32'hFFFF_FFFF);
        wr(12'h3A0, 32'h0000_0018);
        rd(12'h3B0);
        chk("t4_napot_rd", obs_rd, 32'hFFFF_FFFF);
        wr(12'h3A0, 32'h0000_0000);
        rd(12'h3B0);
        chk("t4_off_rd", obs_rd, 32'hFFFF_FFFC);
        chk("t4_bus", addr_bus[(N-1)*34 +: 34], 34'h3_FFFF_FFFC);
        wr(12'h3A0, 32'h0000_0011);
        chk("t4_na4", cfg_bus[(N-1)*6 +: 6], 6'b000001);

        // RLB cannot be set once a region is locked, but can beforehand
        wr(12'h3A0, 32'h0000_0080);
        wr(12'h747, 32'h4);
        chk("t5_rlb_blocked", msec_bus, 3'b000);
        do_reset(1'b0);
        wr(12'h747, 32'h4);
        chk("t5_rlb_set", msec_bus, 3'b100);
        wr(12'h3A0, 32'h0000_0080);
        wr(12'h3A0, 32'h0000_0083);
        chk("t5_rlb_edit", cfg_bus[(N-1)*6 +: 6], 6'b100011);

        // Unmapped, mseccfgh and unimplemented-region accesses
        rd(12'h3C0);
        chk("t6_illegal", obs_ill, 1);
        chk("t6_rdata", obs_rd, 0);
        wr(12'h3C0, 32'hFFFF_FFFF);
        chk("t6_nopulse", pmp_update, 0);
        rd(12'h757);
        chk("t6_msech_legal", obs_ill, 0);
        wr(12'h3B7, 32'hDEAD_BEEF);
        rd(12'h3B7);
        chk("t6_warl_rd", obs_rd, 0);

        // Reset in the middle of a write
        do_reset(1'b1);
        access(1'b0, 1'b0, 12'h3A0, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 400 == 399) do_reset(1'($urandom_range(0, 1)));
            case ($urandom_range(0, 9))
                0, 1, 2: a = 12'h3A0 + 12'($urandom_range(0, 3));
                3, 4, 5: a = 12'h3B0 + 12'($urandom_range(0, 15));
                6:       a = 12'h747;
                7:       a = 12'h757;
                8:       a = 12'($urandom);
                default: a = 12'h3A0 + 12'($urandom_range(0, 31));
            endcase
            d = $urandom;
            if (a[11:4] == 8'h3A && $urandom_range(0, 3) != 0) d = d & 32'h7F7F7F7F;
            if (a == 12'h747 && $urandom_range(0, 3) != 0) d = d & 32'hFFFF_FFFC;
            req = ($urandom_range(0, 7) != 0);
            we  = ($urandom_range(0, 2) != 0);
            access(req, we, a, d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
